motoro3_gate_deadtime: RTL
==========================

// Module: motoro3_gate_deadtime
// PURPOSE
//  Gate-drive stage after motoro3_state_machine / motoro3_pwm_generator. Turns per-phase
//  enable/polarity commands plus the pwm chop into six half-bridge gate signals.
//  Each phase gets a programmable dead time, so the high and low switches of a leg
//  can never conduct together. A latched fault input forces every gate off.
// PARAMETERS
//  DEAD_CYC  10  dead time in clk cycles (1.0us @10MHz); legal range 1..2**CNT_W-1
//  CNT_W     8   width of each per-phase dead-time counter
// PORTS
//  clk       in   1  10MHz system clock; all registers update on its falling edge
//  nRst      in   1  reset, asynchronous, active-low
//  pwm       in   1  chop signal from the pwm generator; gates the high side only
//  aE        in   1  phase A enable (0 = leg floating)
//  aH1_L0    in   1  phase A polarity: 1 = high side, 0 = low side
//  bE        in   1  phase B enable
//  bH1_L0    in   1  phase B polarity
//  cE        in   1  phase C enable
//  cH1_L0    in   1  phase C polarity
//  fault     in   1  over-current / external trip, synchronous to clk, active-high
//  fault_clr in   1  clears the latched fault, one-cycle pulse
//  aHi,aLo   out  1  phase A high-side and low-side gate drive, registered
//  bHi,bLo   out  1  phase B gate drive, registered
//  cHi,cLo   out  1  phase C gate drive, registered
//  dt_busy   out  1  1 while any phase is in DEAD, registered
//  fault_lat out  1  latched fault status
// BEHAVIOUR
//  Per-phase request:
//   - reqHI = E & H1_L0 & pwm
//   - reqLO = E & ~H1_L0
//   - otherwise reqOFF
//  Per-phase FSM {OFF, DEAD, HI, LO} with target register tgt and counter cnt[CNT_W-1:0].
//   - OFF:  gates 00. On reqHI or reqLO: go to DEAD, tgt = that side, cnt = DEAD_CYC-1.
//   - DEAD: gates 00.
//       - reqOFF: go to OFF.
//       - request for the side other than tgt: tgt = new side, cnt = DEAD_CYC-1 (restart).
//       - cnt != 0: cnt decrements.
//       - cnt == 0 and request == tgt: go to tgt.
//   - HI: Hi=1, Lo=0. On any request other than reqHI: Hi=0 at that same edge.
//       Next state is DEAD (tgt = LO, cnt reload) on reqLO, else OFF.
//   - LO: symmetric to HI.
//  Latency:
//   - Turn-off: 1 edge after the request drops.
//   - Turn-on from OFF: the gate asserts on the DEAD_CYC-th edge after the first edge
//     that samples the request.
//   - HI->LO reversal: the gap with both gates 0 is at least DEAD_CYC cycles.
//   - A pwm high pulse shorter than DEAD_CYC cycles never asserts Hi.
//  Invariant: {xHi,xLo} never equals 2'b11, in any state, reset or fault condition.
//  Phases are independent. Simultaneous changes on all three phases are each handled
//  by their own FSM in the same edge.
//  Fault:
//   - fault=1 at an edge: fault_lat <= 1 and all FSMs go to OFF, so all six gates are 0
//     after that edge.
//   - While fault_lat=1, all FSMs are held in OFF.
//   - fault_clr=1 with fault=0 clears fault_lat. Fault wins over a simultaneous clr.
//   - After clear, every phase restarts the full dead time before driving.
//  dt_busy = OR over phases of (next state == DEAD).
//  Reset (nRst=0, asynchronous, also mid-operation):
//   - every FSM is OFF, cnt = 0, tgt = LO;
//   - all gate outputs, dt_busy and fault_lat are 0;
//   - after release, the first drive is again delayed by the full DEAD_CYC.
// TESTING
//  1 Assert nRst=0 with inputs active -> all six gates, dt_busy and fault_lat = 0 at once.
//  2 aE=1, aH1_L0=1, pwm=1 held from OFF -> aHi rises exactly 10 edges later;
//    aLo stays 0; dt_busy=1 for the 10-cycle window.
//  3 Phase A in HI, aH1_L0 -> 0 -> aHi falls on the next edge; aLo rises 10 edges
//    after that; the both-zero gap is >= 10 cycles.
//  4 pwm pulses of 5 cycles high / 20 cycles low with aE=aH1_L0=1 -> aHi stays 0.
//    With 15-cycle high pulses -> aHi high for 5 cycles per pulse.
//  5 fault=1 while B is in HI and C is in LO -> all gates 0 next edge, fault_lat=1.
//    clr with fault=1 is ignored. clr with fault=0 clears; gates return after 10 cycles.
//  6 Drive m3step-style sequence 1..6 at 200-cycle steps with pwm at 50% and a
//    concurrent nRst pulse mid-DEAD -> a checker sees no xHi&xLo, and no turn-on
//    fewer than 10 cycles after that leg's last off.

Source files
------------

// File: rtl/motoro3_gate_deadtime.sv
// rtl/motoro3_gate_deadtime.sv - three-phase gate driver with per-leg dead time and fault latch
module motoro3_gate_deadtime #(
   parameter int DEAD_CYC = 10,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic nRst,
   input  logic pwm,
   input  logic aE,
   input  logic aH1_L0,
   input  logic bE,
   input  logic bH1_L0,
   input  logic cE,
   input  logic cH1_L0,
   input  logic fault,
   input  logic fault_clr,
   output logic aHi,
   output logic aLo,
   output logic bHi,
   output logic bLo,
   output logic cHi,
   output logic cLo,
   output logic dt_busy,
   output logic fault_lat
);

   typedef enum logic [1:0] {S_OFF, S_DEAD, S_HI, S_LO} state_t;

   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // index 0 = phase A, 1 = phase B, 2 = phase C
   logic [2:0]       req_hi;
   logic [2:0]       req_lo;
   state_t           state_q [3];
   state_t           state_d [3];
   logic [2:0]       tgt_q;        // 1 = high side pending/driven, 0 = low side
   logic [2:0]       tgt_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [2:0]       hi_q;
   logic [2:0]       lo_q;
   logic [2:0]       dead_d;
   logic             hold_off;

   // The chop only ever gates the high side; the low side follows enable alone.
   assign req_hi = {cE & cH1_L0 & pwm, bE & bH1_L0 & pwm, aE & aH1_L0 & pwm};
   assign req_lo = {cE & ~cH1_L0,      bE & ~bH1_L0,      aE & ~aH1_L0};

   // A trip in this cycle or a still-latched trip both force every leg off.
   assign hold_off = fault | fault_lat;

   // Per-leg next state: the high and low switch are never commanded together,
   // and any side change passes through DEAD for the full reload count.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         state_d[p] = state_q[p];
         tgt_d[p]   = tgt_q[p];
         cnt_d[p]   = cnt_q[p];
         dead_d[p]  = 1'b0;
         if (hold_off) begin
            state_d[p] = S_OFF;
         end else begin
            case (state_q[p])
               S_OFF: begin
                  if (req_hi[p] || req_lo[p]) begin
                     state_d[p] = S_DEAD;
                     tgt_d[p]   = req_hi[p];
                     cnt_d[p]   = RELOAD;
                  end
               end
               S_DEAD: begin
                  if (!req_hi[p] && !req_lo[p]) begin
                     state_d[p] = S_OFF;
                  end else if (req_hi[p] != tgt_q[p]) begin
                     // side flipped while waiting: the whole dead time starts over
                     tgt_d[p] = req_hi[p];
                     cnt_d[p] = RELOAD;
                  end else if (cnt_q[p] != '0) begin
                     cnt_d[p] = cnt_q[p] - CNT_ONE;
                  end else begin
                     state_d[p] = tgt_q[p] ? S_HI : S_LO;
                  end
               end
               S_HI: begin
                  if (req_lo[p]) begin
                     state_d[p] = S_DEAD;
                     tgt_d[p]   = 1'b0;
                     cnt_d[p]   = RELOAD;
                  end else if (!req_hi[p]) begin
                     state_d[p] = S_OFF;
                  end
               end
               S_LO: begin
                  if (req_hi[p]) begin
                     state_d[p] = S_DEAD;
                     tgt_d[p]   = 1'b1;
                     cnt_d[p]   = RELOAD;
                  end else if (!req_lo[p]) begin
                     state_d[p] = S_OFF;
                  end
               end
               default: begin
                  state_d[p] = S_OFF;
               end
            endcase
         end
         dead_d[p] = (state_d[p] == S_DEAD);
      end
   end

   // Leg state and gate registers; gates decode from the next state so they
   // drop on the same edge that leaves HI/LO.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         for (int p = 0; p < 3; p++) begin
            state_q[p] <= S_OFF;
            cnt_q[p]   <= '0;
         end
         tgt_q   <= 3'b000;
         hi_q    <= 3'b000;
         lo_q    <= 3'b000;
         dt_busy <= 1'b0;
      end else begin
         for (int p = 0; p < 3; p++) begin
            state_q[p] <= state_d[p];
            cnt_q[p]   <= cnt_d[p];
            hi_q[p]    <= (state_d[p] == S_HI);
            lo_q[p]    <= (state_d[p] == S_LO);
         end
         tgt_q   <= tgt_d;
         dt_busy <= |dead_d;
      end
   end

   // Fault latch: a trip always wins over a simultaneous clear.
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         fault_lat <= 1'b0;
      end else if (fault) begin
         fault_lat <= 1'b1;
      end else if (fault_clr) begin
         fault_lat <= 1'b0;
      end
   end

   assign aHi = hi_q[0];
   assign aLo = lo_q[0];
   assign bHi = hi_q[1];
   assign bLo = lo_q[1];
   assign cHi = hi_q[2];
   assign cLo = lo_q[2];

endmodule
